// File: rtl/poly1305_block_formatter.sv
// Poly1305 MAC input formatter: builds RFC 8439 padded AAD/CT blocks plus the
// length block, each as a 130-bit operand {2'b01, block}, behind a one-entry
// registered valid/ready output.
// Optional feature macro: POLY_FMT_ERR_CHECK_EN (protocol checks and sticky err).
module poly1305_block_formatter (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic [4:0]   s_nbytes,
  input  logic         s_last,
  input  logic         s_type,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [129:0] m_block,
  output logic         m_last,
  output logic         busy,
  output logic         err
);

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned BLK_W   = 130;
  localparam int unsigned NB_W    = 5;
  localparam int unsigned LEN_W   = 64;
  localparam int unsigned N_BYTES = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AAD  = 2'd1;
  localparam logic [1:0] ST_CT   = 2'd2;
  localparam logic [1:0] ST_LEN  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_m_valid;
  logic              r_m_last;
  logic [BLK_W-1:0]  r_m_block;
  logic [LEN_W-1:0]  r_aad_len;
  logic [LEN_W-1:0]  r_ct_len;
  logic              r_err;

  logic              w_can_load;
  logic              w_in_seg;
  logic              w_acc;
  logic              w_bad;
  logic              w_good;
  logic              w_emit;
  logic              w_seg_done;
  logic              w_len_load;
  logic              w_len_done;
  logic [NB_W-1:0]   w_nbytes;
  logic [DATA_W-1:0] w_masked;

  // Handshake qualifiers
  assign w_can_load = !r_m_valid || m_ready;
  assign w_in_seg   = (r_state == ST_AAD) || (r_state == ST_CT);
  assign s_ready    = w_in_seg && !start && w_can_load;
  assign w_acc      = s_valid && s_ready;
  assign w_good     = w_acc && !w_bad;
  assign w_emit     = w_good && (w_nbytes != NB_W'(0));
  assign w_seg_done = w_good && s_last;
  // Length block loads once; an already-loaded length block is marked by m_last
  assign w_len_load = (r_state == ST_LEN) && !start && w_can_load && !(r_m_valid && r_m_last);
  assign w_len_done = (r_state == ST_LEN) && r_m_valid && r_m_last && m_ready;

  // Oversized byte counts behave as a full beat
  assign w_nbytes = (s_nbytes > NB_W'(N_BYTES)) ? NB_W'(N_BYTES) : s_nbytes;

  // Zero every byte at or above the valid byte count
  always_comb begin
    w_masked = '0;
    for (int k = 0; k < 16; k++) begin
      if (NB_W'(k) < w_nbytes) begin
        w_masked[8*k +: 8] = s_data[8*k +: 8];
      end
    end
  end

`ifdef POLY_FMT_ERR_CHECK_EN
  // Protocol violation detection on the presented beat
  always_comb begin
    w_bad = 1'b0;
    if (s_nbytes > NB_W'(N_BYTES))               w_bad = 1'b1;
    if ((s_nbytes < NB_W'(N_BYTES)) && !s_last)  w_bad = 1'b1;
    if ((r_state == ST_AAD) && s_type)           w_bad = 1'b1;
    if ((r_state == ST_CT) && !s_type)           w_bad = 1'b1;
  end

  // Sticky error flag, cleared only by start or reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (start) begin
      r_err <= 1'b0;
    end else if (w_acc && w_bad) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused_type;
  assign w_unused_type = s_type;
  assign w_bad         = 1'b0;
  assign r_err         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_AAD;
    end else begin
      case (r_state)
        ST_AAD:  if (w_seg_done) w_state_nxt = ST_CT;
        ST_CT:   if (w_seg_done) w_state_nxt = ST_LEN;
        ST_LEN:  if (w_len_done) w_state_nxt = ST_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // One-entry output register toward the multiplier
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_block <= '0;
    end else if (start) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_emit) begin
      r_m_valid <= 1'b1;
      r_m_last  <= 1'b0;
      r_m_block <= {2'b01, w_masked};
    end else if (w_len_load) begin
      r_m_valid <= 1'b1;
      r_m_last  <= 1'b1;
      r_m_block <= {2'b01, r_ct_len, r_aad_len};
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  // Segment byte counters, modulo 2^64
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_aad_len <= '0;
      r_ct_len  <= '0;
    end else if (start) begin
      r_aad_len <= '0;
      r_ct_len  <= '0;
    end else if (w_good && (r_state == ST_AAD)) begin
      r_aad_len <= r_aad_len + LEN_W'(w_nbytes);
    end else if (w_good && (r_state == ST_CT)) begin
      r_ct_len  <= r_ct_len + LEN_W'(w_nbytes);
    end
  end

  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_block = r_m_block;
  assign busy    = (r_state != ST_IDLE);
  assign err     = r_err;

endmodule

// File: doc/poly1305_block_formatter.md
# poly1305_block_formatter

Upstream feeder for the Poly1305 MAC datapath in the ChaCha20-Poly1305 AEAD core. It takes AAD and ciphertext as 16-byte little-endian beats and builds the RFC 8439 MAC input: each segment is zero-padded to 16 bytes and followed by the 16-byte length block. Every MAC block is emitted as a 130-bit operand with the 2^128 bit set, ready for the accumulate/multiply/reduce stage. A one-entry registered output gives a clean valid/ready handshake toward the multiplier.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a new message. Clears counters, state and error.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  128  beat data; byte k is s_data[8k+7:8k].
- s_nbytes  in  5  number of valid bytes, 0..16.
- s_last  in  1  last beat of the current segment.
- s_type  in  1  0 = AAD, 1 = ciphertext.
- m_valid  out  1  output block valid.
- m_ready  in  1  downstream accepts the block.
- m_block  out  130  {2'b01, 128-bit padded block}.
- m_last  out  1  qualifies the length block, which is the final block of the message.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky protocol error.

## Operation
- States: IDLE, AAD, CT, LEN.
  - Reset enters IDLE. start (from any state) enters AAD.
  - AAD to CT on an accepted AAD beat with s_last=1.
  - CT to LEN on an accepted CT beat with s_last=1.
  - LEN to IDLE when the length block handshakes.
- Data beats:
  - Bytes at index ≥ s_nbytes are forced to zero.
  - m_block = {2'b01, masked s_data}.
  - The segment byte counter (aad_len or ct_len, 64-bit) increments by s_nbytes and wraps modulo 2^64.
- Empty segment: a beat with s_nbytes=0 and s_last=1 is accepted, advances the state, and emits no block.
- Length block: m_block = {2'b01, ct_len[63:0], aad_len[63:0]} (ct_len in bits 127:64), with m_last=1.
- Protocol errors (with checks enabled). The beat is accepted and discarded: no block, no count, no state change. err is set.
  - s_nbytes > 16.
  - s_nbytes < 16 with s_last=0.
  - s_nbytes=0 with s_last=0.
  - s_type not matching the state (1 in AAD, 0 in CT).
- err clears only on start or reset. Processing continues after an error.

## Timing
- Reset values: s_ready=0, m_valid=0, m_block=0, m_last=0, busy=0, err=0. Internal state: IDLE, counters 0.
- s_ready = (state is AAD or CT) && !start && (!m_valid || m_ready).
  - Full throughput: one block per cycle.
  - Latency from accepted beat to m_valid is 1 cycle.
- The length block loads into the output register in the first LEN cycle in which !m_valid || m_ready holds.
- While m_valid=1 && m_ready=0, m_block and m_last hold stable.
- start mid-message:
  - The pending output is dropped: m_valid=0 on the next cycle.
  - Counters are zeroed and the state becomes AAD.
  - A beat presented in the start cycle is not accepted.
- start in the same cycle as an output handshake: the handshake completes, then the message is aborted.

## Configuration
- POLY_FMT_ERR_CHECK_EN defined: protocol checks and err are as described above.
- Not defined:
  - err is tied to 0 and no checks are made.
  - s_nbytes > 16 is treated as 16 for masking and counting.
  - s_type is ignored; the segment is taken from the state.

## Test plan
- AAD 12 bytes (one beat, nbytes=12, last) then CT 20 bytes (beats of 16 and 4, last) -> 4 blocks:
  - AAD block with bytes 12..15 zero.
  - Full CT block.
  - CT block with bytes 4..15 zero.
  - Length block {2'b01, 64'h14, 64'h0C}, m_last=1.
  - All blocks have bit 128 = 1.
- Empty AAD (nbytes=0, last) then CT 16 bytes -> 2 blocks; the length block is {2'b01, 64'h10, 64'h0}.
- m_ready held low for 5 cycles on the first block -> s_ready=0 and m_block stable throughout. No data is lost after release.
- CT beat sent in AAD state (checks enabled) -> err=1 and no block is emitted. A following start clears err to 0.
- start asserted while m_valid=1 && m_ready=0 mid-CT -> m_valid=0 the next cycle. A new message then yields a length block with counts from zero only.
- reset_n pulsed low mid-message -> all outputs return to reset values immediately (asynchronous), and busy=0.
